flow_table_resp: RTL
====================

// Module: flow_table_resp
// PURPOSE
//  Responder side of the of_lookup_* handshake issued by the per-port forwarder.
//  Holds a small register-based exact-match flow table (key -> egress port bitmap).
//  On each request it scans the table linearly and returns one ack carrying either the
//  first matching entry's port bitmap or an error. Sits in the sys_clk domain beside the
//  forwarders; table entries are written by a management/CPU write port.
// PARAMETERS
//  NPORT   4    egress port count; width of the forward bitmap
//  KEY_W   116  lookup key width (flow tuple)
//  DEPTH   8    table entries, power of two, 2..64
//  AW      3    entry address width, = log2(DEPTH)
// PORTS
//  sys_clk              in   1      single clock
//  sys_rst_n            in   1      asynchronous active-low reset
//  of_lookup_req        in   1      1-cycle request strobe
//  of_lookup_data       in   KEY_W  key, valid only while req=1
//  of_lookup_ack        out  1      1-cycle response strobe
//  of_lookup_err        out  1      1 = miss; qualified by ack
//  of_lookup_fwd_port   out  NPORT  egress bitmap; qualified by ack
//  tbl_wr_en            in   1      write one table entry
//  tbl_wr_addr          in   AW     entry index
//  tbl_wr_valid         in   1      entry valid bit to write (0 = delete)
//  tbl_wr_key           in   KEY_W  entry key
//  tbl_wr_port          in   NPORT  entry egress bitmap
//  busy                 out  1      1 while state != IDLE
//  stat_rd_addr         in   AW     [FLOW_STATS_EN] counter select
//  stat_rd_data         out  32     [FLOW_STATS_EN] hit count of selected entry, combinational
//  stat_miss_cnt        out  32     [FLOW_STATS_EN] total misses
// BEHAVIOUR
//  Reset: ack=0, err=0, fwd_port=0, busy=0, state=IDLE, all entry valid bits=0.
//   Keys and ports are not reset. All counters = 0.
//  FSM IDLE -> SCAN -> RESP -> IDLE.
//   IDLE: req=1 at cycle T latches the key and sets idx=0. Next state SCAN.
//   SCAN: compares entry idx during cycle T+1+idx (valid && key==latched key).
//    On hit: registers the port bitmap; err=0. On miss at idx=DEPTH-1: fwd_port=0, err=1.
//    Either outcome goes to RESP. Otherwise idx++.
//   RESP: ack=1 for exactly one cycle, then IDLE.
//  Latency: hit on entry i -> ack at T+2+i. Miss -> ack at T+DEPTH+1.
//  Among duplicate keys, the lowest index wins.
//  fwd_port/err hold their value after ack until the next response. They are only
//   meaningful with ack=1.
//  req while busy=1 is ignored (dropped, not queued). req in the same cycle the FSM
//   returns to IDLE (RESP cycle) is also ignored. The initiator must wait for ack.
//  Table write: takes effect at the next clock edge. A write to the entry being compared
//   in the same cycle compares against the old contents. Writes to other entries during
//   SCAN are allowed and are visible if the scan has not yet passed that index.
//  idx is AW+1 bits internally. No wrap: the scan terminates at DEPTH-1.
//  Reset mid-scan: the FSM returns to IDLE at once, and no ack is ever issued for the
//   aborted request.
// CONFIGURATION
//  FLOW_STATS_EN defined: adds per-entry 32-bit hit counters, incremented on the same
//   edge that registers a hit. Also adds a 32-bit miss counter. Counters saturate at
//   0xFFFFFFFF. A table write to an entry clears that entry's hit counter (the write wins
//   over a simultaneous hit). The stat_* ports exist.
//  FLOW_STATS_EN undefined: no counters and no stat_* ports. Lookup timing is identical.
// STRUCTURE
//  Shared package: FLOW_KEY_W=116, FLOW_NPORT=4, FSM state encodings
//   (IDLE=2'd0, SCAN=2'd1, RESP=2'd2). These are shared with the forwarder and its test.
//  One sub-module, flow_hit_counters: counter array, saturation and clear-on-write.
//   It is instantiated only under FLOW_STATS_EN.
//  Table storage is in flops. No RAM primitive is used, because a simultaneous write
//   and compare must be possible.
// TESTING
//  1. Reset, then req with any key -> ack at T+DEPTH+1=T+9, err=1, fwd_port=4'b0000.
//  2. Write entry 3 (key K1, port 4'b0100). req K1 -> ack at T+5, err=0, fwd_port=4'b0100.
//  3. Write entries 2 and 6 with key K2 (ports 4'b0001 and 4'b1000). req K2 -> fwd_port=4'b0001
//     at T+4. Delete entry 2, req K2 -> 4'b1000 at T+8.
//  4. Issue req, then a second req at T+1 and another at T+3 -> exactly one ack. busy=1
//     from T+1 until the ack cycle.
//  5. Write entry 5 with K3 in cycle T+6 of a K3 scan (entry 5 under compare) -> miss
//     ack at T+9. A repeat req K3 -> hit, ack at T+7.
//  6. FLOW_STATS_EN: 3 hits on entry 3 and 2 misses -> stat_rd_data(3)=3, stat_miss_cnt=2.
//     Rewrite entry 3 -> stat_rd_data(3)=0. Assert sys_rst_n low mid-scan -> no ack,
//     all counters 0.

Source files
------------

// File: rtl/flow_table_resp_pkg.sv
// Shared definitions for the flow-table responder, the per-port forwarders and their tests.
package flow_table_resp_pkg;

    localparam int FLOW_KEY_W = 116;
    localparam int FLOW_NPORT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } flow_state_e;

endpackage

// File: rtl/flow_hit_counters.sv
// Per-entry saturating hit counters and a saturating miss counter.
// A table write to an entry clears its counter and takes priority over a simultaneous hit.
module flow_hit_counters #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hit,
    input  logic [AW-1:0] hit_idx,
    input  logic          miss,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   miss_cnt
);

    logic [31:0] hit_cnt [DEPTH];
    logic [31:0] miss_cnt_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            logic        clr;
            logic        inc;

            assign clr = wr_en && (wr_addr == AW'(gi));
            assign inc = hit && (hit_idx == AW'(gi)) && (cnt_reg != 32'hFFFF_FFFF);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (inc) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            assign hit_cnt[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_reg <= '0;
        end else if (miss && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign rd_data  = hit_cnt[rd_addr];
    assign miss_cnt = miss_cnt_reg;

endmodule

// File: rtl/flow_table_resp.sv
// Exact-match flow table responder: linear scan, one ack per accepted request.
// Optional per-entry hit / miss statistics are built when FLOW_STATS_EN is defined.
module flow_table_resp
    import flow_table_resp_pkg::*;
#(
    parameter int NPORT = FLOW_NPORT,
    parameter int KEY_W = FLOW_KEY_W,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             of_lookup_req,
    input  logic [KEY_W-1:0] of_lookup_data,
    output logic             of_lookup_ack,
    output logic             of_lookup_err,
    output logic [NPORT-1:0] of_lookup_fwd_port,
    input  logic             tbl_wr_en,
    input  logic [AW-1:0]    tbl_wr_addr,
    input  logic             tbl_wr_valid,
    input  logic [KEY_W-1:0] tbl_wr_key,
    input  logic [NPORT-1:0] tbl_wr_port,
    output logic             busy
`ifdef FLOW_STATS_EN
    ,
    input  logic [AW-1:0]    stat_rd_addr,
    output logic [31:0]      stat_rd_data,
    output logic [31:0]      stat_miss_cnt
`endif
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    logic             tbl_valid [DEPTH];
    logic [KEY_W-1:0] tbl_key   [DEPTH];
    logic [NPORT-1:0] tbl_port  [DEPTH];

    // Entries live in flops so a write and a compare of the same entry can share a cycle;
    // the compare then sees the pre-write contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic             valid_reg;
            logic [KEY_W-1:0] key_reg;
            logic [NPORT-1:0] port_reg;
            logic             sel;

            assign sel = tbl_wr_en && (tbl_wr_addr == AW'(gi));

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    valid_reg <= tbl_wr_valid;
                end
            end

            always_ff @(posedge sys_clk) begin
                if (sel) begin
                    key_reg  <= tbl_wr_key;
                    port_reg <= tbl_wr_port;
                end
            end

            assign tbl_valid[gi] = valid_reg;
            assign tbl_key[gi]   = key_reg;
            assign tbl_port[gi]  = port_reg;
        end
    endgenerate

    flow_state_e      state_reg;
    logic [AW:0]      idx_reg;
    logic [KEY_W-1:0] lookup_key_reg;
    logic             ack_reg;
    logic             err_reg;
    logic [NPORT-1:0] fwd_reg;
    logic             busy_reg;

    logic [AW-1:0]    cmp_addr;
    logic             cmp_match;
    logic             scan_hit;
    logic             scan_miss;

    assign cmp_addr  = idx_reg[AW-1:0];
    assign cmp_match = tbl_valid[cmp_addr] && (tbl_key[cmp_addr] == lookup_key_reg);
    assign scan_hit  = (state_reg == SCAN) && cmp_match;
    assign scan_miss = (state_reg == SCAN) && !cmp_match && (idx_reg == LAST_IDX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            lookup_key_reg <= '0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            fwd_reg        <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    if (of_lookup_req) begin
                        lookup_key_reg <= of_lookup_data;
                        idx_reg        <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        fwd_reg   <= tbl_port[cmp_addr];
                        err_reg   <= 1'b0;
                        ack_reg   <= 1'b1;
                        state_reg <= RESP;
                    end else if (scan_miss) begin
                        fwd_reg   <= '0;
                        err_reg   <= 1'b1;
                        ack_reg   <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                RESP: begin
                    // Requests arriving in this cycle are dropped, not queued.
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign of_lookup_ack      = ack_reg;
    assign of_lookup_err      = err_reg;
    assign of_lookup_fwd_port = fwd_reg;
    assign busy               = busy_reg;

`ifdef FLOW_STATS_EN
    flow_hit_counters #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_hit_counters (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .hit      (scan_hit),
        .hit_idx  (cmp_addr),
        .miss     (scan_miss),
        .wr_en    (tbl_wr_en),
        .wr_addr  (tbl_wr_addr),
        .rd_addr  (stat_rd_addr),
        .rd_data  (stat_rd_data),
        .miss_cnt (stat_miss_cnt)
    );
`endif

endmodule
